// File: rtl/mm_pkg.sv
// Shared matrix-multiply datapath definitions: pack-stage state encoding,
// default element width and the ceiling-log2 helper used for index/sum widths.
package mm_pkg;

    localparam int unsigned W_U_DEFAULT = 8;

    localparam logic FILL = 1'b0;
    localparam logic FULL = 1'b1;

    // Bits needed to index v distinct values (0 for v<=1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vector_pack_if.sv
// Element stream in / packed vector out bundle for vector_pack.
// in_last exists only when VECTOR_PACK_LAST_EN is defined.
interface vector_pack_if
    import mm_pkg::*;
#(
    parameter int unsigned DIM = 5,
    parameter int unsigned W_u = W_U_DEFAULT
);
    logic [W_u-1:0]     in_data;
    logic               in_valid;
    logic               in_ready;
`ifdef VECTOR_PACK_LAST_EN
    logic               in_last;
`endif
    logic [DIM*W_u-1:0] out_vec;
    logic               out_valid;
    logic               out_ready;

`ifdef VECTOR_PACK_LAST_EN
    modport master (output in_data, output in_valid, input in_ready, output in_last,
                    input out_vec, input out_valid, output out_ready);
    modport slave  (input in_data, input in_valid, output in_ready, input in_last,
                    output out_vec, output out_valid, input out_ready);
`else
    modport master (output in_data, output in_valid, input in_ready,
                    input out_vec, input out_valid, output out_ready);
    modport slave  (input in_data, input in_valid, output in_ready,
                    output out_vec, output out_valid, input out_ready);
`endif

endinterface

// File: rtl/vector_pack.sv
// Packs DIM serial W_u-bit elements into one vector for vectorSum, double-buffered.
// Optional early close via in_last when VECTOR_PACK_LAST_EN is defined.
module vector_pack
    import mm_pkg::*;
#(
    parameter int unsigned DIM = 5,
    parameter int unsigned W_u = W_U_DEFAULT
) (
    input  logic          Clock,
    input  logic          Reset_n,
    vector_pack_if.slave  bus
);

    localparam int unsigned IDX_W = (clog2(DIM) > 1) ? clog2(DIM) : 1;
    localparam int unsigned VEC_W = DIM * W_u;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);

    logic              state;
    logic              state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [W_u-1:0]    fill [DIM];
    logic [VEC_W-1:0]  vec_q;
    logic              vld_q;

    logic              last_c;
    logic              in_ready_c;
    logic              xfer_in_c;
    logic              xfer_out_c;
    logic              complete_c;
    logic              slot_free_c;
    logic [VEC_W-1:0]  pack_c;

`ifdef VECTOR_PACK_LAST_EN
    assign last_c = bus.in_last;
`else
    assign last_c = 1'b0;
`endif

    assign xfer_in_c   = bus.in_valid && in_ready_c;
    assign xfer_out_c  = vld_q && bus.out_ready;
    assign complete_c  = xfer_in_c && ((idx == IDX_MAX) || last_c);
    assign slot_free_c = !vld_q || bus.out_ready;

    // Element 0 lands in the top slice; in FILL the arriving element is merged at idx.
    always_comb begin
        pack_c = '0;
        for (int k = 0; k < DIM; k++) begin
            if ((state == FILL) && (IDX_W'(k) == idx))
                pack_c[VEC_W-1-k*W_u -: W_u] = bus.in_data;
            else
                pack_c[VEC_W-1-k*W_u -: W_u] = fill[k];
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= FILL;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (complete_c && !slot_free_c) state_nxt = FULL;
            FULL:    if (xfer_out_c)                 state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        if (Reset_n && (state == FILL)) in_ready_c = 1'b1;
    end

    // Fill register, index and output register; slots are zeroed on every hand-off.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            idx   <= '0;
            fill  <= '{default: '0};
            vec_q <= '0;
            vld_q <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (xfer_out_c) vld_q <= 1'b0;
                    if (complete_c && slot_free_c) begin
                        vec_q <= pack_c;
                        vld_q <= 1'b1;
                        idx   <= '0;
                        fill  <= '{default: '0};
                    end else if (complete_c) begin
                        fill[idx] <= bus.in_data;
                    end else if (xfer_in_c) begin
                        fill[idx] <= bus.in_data;
                        idx       <= idx + IDX_W'(1);
                    end
                end
                FULL: begin
                    if (xfer_out_c) begin
                        vec_q <= pack_c;
                        idx   <= '0;
                        fill  <= '{default: '0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_vec   = vec_q;
    assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_vector_pack.sv
// Scoreboard bench for vector_pack (DIM=5, W_u=8); define VECTOR_PACK_LAST_EN to cover in_last.
module tb_vector_pack;

    localparam int unsigned DIM = 5;
    localparam int unsigned W   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_pack_if #(.DIM(DIM), .W_u(W)) bus ();

    vector_pack #(.DIM(DIM), .W_u(W)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    logic [39:0] exp_q [$];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pop and compare whenever a vector is about to be taken.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected vector: got %h expected none", bus.out_vec);
            end else begin
                check("scoreboard vector", bus.out_vec, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] v, input logic last);
        int wait_n;
        wait_n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
`ifdef VECTOR_PACK_LAST_EN
        bus.in_last  = last;
`else
        if (last) $display("in_last ignored in this build");
`endif
        @(negedge clk);
        while (!bus.in_ready && wait_n < 50) begin
            wait_n++;
            stalls++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send timeout: got in_ready 0 expected 1 for element %h", v);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
`ifdef VECTOR_PACK_LAST_EN
        bus.in_last  = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
`ifdef VECTOR_PACK_LAST_EN
        bus.in_last   = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 40'(bus.out_valid), 40'd0);
        check("reset out_vec", bus.out_vec, 40'd0);
        check("reset in_ready", 40'(bus.in_ready), 40'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 40'(bus.in_ready), 40'd1);
        @(posedge clk);
        #1;

        // 1..5 back-to-back with consumer ready
        bus.out_ready = 1'b1;
        exp_q.push_back(40'h0102030405);
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b0);
        check("valid on last accept", 40'(bus.out_valid), 40'd1);
        check("vector on last accept", bus.out_vec, 40'h0102030405);
        idle(1);
        check("valid one cycle", 40'(bus.out_valid), 40'd0);

        // Consumer stalled: second vector parks in the fill register
        bus.out_ready = 1'b0;
        exp_q.push_back(40'h0102030405);
        exp_q.push_back(40'h060708090A);
        for (int v = 1; v <= 10; v++) send(8'(v), 1'b0);
        check("in_ready drops when full", 40'(bus.in_ready), 40'd0);
        check("held vector", bus.out_vec, 40'h0102030405);
        idle(1);
        check("held vector stable", bus.out_vec, 40'h0102030405);
        check("held valid stable", 40'(bus.out_valid), 40'd1);
        bus.out_ready = 1'b1;
        idle(1);
        bus.out_ready = 1'b0;
        check("full to fill vector", bus.out_vec, 40'h060708090A);
        check("full to fill valid", 40'(bus.out_valid), 40'd1);
        check("full to fill in_ready", 40'(bus.in_ready), 40'd1);
        bus.out_ready = 1'b1;
        idle(1);
        check("drained valid", 40'(bus.out_valid), 40'd0);

        // Input bubbles between elements
        exp_q.push_back(40'h0102030405);
        for (int v = 1; v <= 5; v++) begin
            send(8'(v), 1'b0);
            for (int b = 0; b < (v % 3) + 1; b++) begin
                bus.in_data = 8'hA5;
                check("in_ready during bubble", 40'(bus.in_ready), 40'd1);
                idle(1);
            end
        end
        idle(2);

        // Reset mid-vector discards partial data
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 40'(bus.out_valid), 40'd0);
        check("mid reset in_ready", 40'(bus.in_ready), 40'd0);
        idle(2);
        rst_n = 1'b1;
        exp_q.push_back(40'h060708090A);
        for (int v = 6; v <= 10; v++) send(8'(v), 1'b0);
        idle(2);

        // Continuous 1..15, no stalls expected
        stalls = 0;
        exp_q.push_back(40'h0102030405);
        exp_q.push_back(40'h060708090A);
        exp_q.push_back(40'h0B0C0D0E0F);
        for (int v = 1; v <= 15; v++) send(8'(v), 1'b0);
        check("continuous stalls", 40'(stalls), 40'd0);
        idle(2);

`ifdef VECTOR_PACK_LAST_EN
        exp_q.push_back(40'h0102030000);
        exp_q.push_back(40'h0405060708);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b1);
        check("early close vector", bus.out_vec, 40'h0102030000);
        for (int v = 4; v <= 8; v++) send(8'(v), 1'b0);
        idle(2);
`endif

        check("scoreboard drained", 40'(exp_q.size()), 40'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
